// File: rtl/usb_rx_pkt_ctrl_if.sv
// Bus between the USB byte receiver / SIE endpoint logic and the packet
// controller. The receiver side (and the device address) drives the rx_*
// signals; the controller drives the per-packet event outputs.
interface usb_rx_pkt_ctrl_if;
  // Byte receiver stream and device address
  logic [7:0]  rx_data;
  logic        rx_active;
  logic        rx_valid;
  logic        rx_error;
  logic [6:0]  dev_addr;

  // Token / SOF / handshake events
  logic        tok_valid;
  logic [3:0]  tok_pid;
  logic [3:0]  tok_endp;
  logic        sof_valid;
  logic [10:0] sof_frame;
  logic        hs_valid;
  logic [3:0]  hs_pid;

  // Data packet stream
  logic        dat_start;
  logic [3:0]  dat_pid;
  logic [7:0]  dat_byte;
  logic        dat_strobe;
  logic        dat_end;
  logic        dat_ok;

  // Rejection report
  logic        pkt_err;
  logic [2:0]  err_code;

  // Receiver / SIE side
  modport master (
    output rx_data, rx_active, rx_valid, rx_error, dev_addr,
    input  tok_valid, tok_pid, tok_endp, sof_valid, sof_frame, hs_valid, hs_pid,
           dat_start, dat_pid, dat_byte, dat_strobe, dat_end, dat_ok,
           pkt_err, err_code
  );

  // Packet controller side
  modport slave (
    input  rx_data, rx_active, rx_valid, rx_error, dev_addr,
    output tok_valid, tok_pid, tok_endp, sof_valid, sof_frame, hs_valid, hs_pid,
           dat_start, dat_pid, dat_byte, dat_strobe, dat_end, dat_ok,
           pkt_err, err_code
  );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// USB low/full-speed receive packet controller. Sequences each packet from
// PID to end of packet, checks PID/length/CRC5/CRC16, filters tokens by
// device address and emits one registered event per packet. Data payload
// bytes pass through a 2-byte holdback so the trailing CRC16 is never output.
module usb_rx_pkt_ctrl #(
  parameter int MAX_PAYLOAD = 64,
  parameter int CNT_W       = 11
) (
  input logic              clk,
  input logic              reset_n,
  usb_rx_pkt_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_WAIT_IDLE
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_PID   = 3'd1,
    ERR_CRC   = 3'd2,
    ERR_LEN   = 3'd3,
    ERR_RX    = 3'd4,
    ERR_OVF   = 3'd5,
    ERR_UNSUP = 3'd6
  } err_e;

  localparam logic [3:0]       PID_SOF   = 4'b0101;
  localparam logic [4:0]       CRC5_INIT = 5'h1F;
  localparam logic [4:0]       CRC5_RES  = 5'h06;
  localparam logic [15:0]      CRC16_INIT = 16'hFFFF;
  localparam logic [15:0]      CRC16_RES  = 16'hB001;
  // Byte count after the PID saturates here (payload + 2 CRC + 1 excess)
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD + 3);
  // Highest byte count whose oldest held byte is still a legal payload byte
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_PAYLOAD + 2);

  // One CRC5 step per bit, LSB first, reflected polynomial
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = {1'b0, c[4:1]} ^ 5'h14;
      else                c = {1'b0, c[4:1]};
    end
    return c;
  endfunction

  // One CRC16 step per bit, LSB first, reflected polynomial
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = {1'b0, c[15:1]} ^ 16'hA001;
      else                c = {1'b0, c[15:1]};
    end
    return c;
  endfunction

  // Registered receiver inputs
  logic [7:0]       rx_data_q;
  logic             rx_active_q;
  logic             rx_valid_q;
  logic             rx_error_q;
  logic [6:0]       dev_addr_q;

  // Packet sequencing state
  state_e           state_q;
  logic             fresh_q;
  logic [3:0]       pid_q;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [10:0]      field_q, field_d;
  logic [4:0]       crc5_q,  crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [7:0]       hold0_q, hold0_d;
  logic [7:0]       hold1_q, hold1_d;
  logic             ovf_q,   ovf_d;
  logic             strobe_d;

  // Registered event outputs
  logic             tok_valid_q;
  logic [3:0]       tok_pid_q;
  logic [3:0]       tok_endp_q;
  logic             sof_valid_q;
  logic [10:0]      sof_frame_q;
  logic             hs_valid_q;
  logic [3:0]       hs_pid_q;
  logic             dat_start_q;
  logic [3:0]       dat_pid_q;
  logic [7:0]       dat_byte_q;
  logic             dat_strobe_q;
  logic             dat_end_q;
  logic             dat_ok_q;
  logic             pkt_err_q;
  err_e             err_code_q;

  // Capture receiver inputs as-is
  // NOTE: these capture flops are deliberately left out of reset so that the
  // first cycle after release already sees the real rx_active level, which
  // is what decides between IDLE and WAIT_IDLE for an in-flight packet.
  always_ff @(posedge clk) begin
    rx_data_q   <= bus.rx_data;
    rx_active_q <= bus.rx_active;
    rx_valid_q  <= bus.rx_valid;
    rx_error_q  <= bus.rx_error;
    dev_addr_q  <= bus.dev_addr;
  end

  // Per-byte datapath update: counter, token field, CRCs, holdback, overflow
  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    field_d  = field_q;
    crc5_d   = crc5_q;
    crc16_d  = crc16_q;
    hold0_d  = hold0_q;
    hold1_d  = hold1_q;
    strobe_d = 1'b0;
    if (rx_valid_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(0)) field_d[7:0]  = rx_data_q;
      if (cnt_q == CNT_W'(1)) field_d[10:8] = rx_data_q[2:0];
      if (cnt_q <  CNT_W'(2)) crc5_d = crc5_byte(crc5_q, rx_data_q);
      crc16_d  = crc16_byte(crc16_q, rx_data_q);
      hold0_d  = hold1_q;
      hold1_d  = rx_data_q;
      // A third byte pushes the oldest held byte out, unless it is past MAX
      strobe_d = (cnt_q >= CNT_W'(2)) && (cnt_d <= CNT_LIM);
    end
    ovf_d = ovf_q | (cnt_d > CNT_LIM);
  end

  // Packet FSM with registered event outputs
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fresh_q      <= 1'b1;
      pid_q        <= '0;
      cnt_q        <= '0;
      field_q      <= '0;
      crc5_q       <= CRC5_INIT;
      crc16_q      <= CRC16_INIT;
      hold0_q      <= '0;
      hold1_q      <= '0;
      ovf_q        <= 1'b0;
      tok_valid_q  <= 1'b0;
      tok_pid_q    <= '0;
      tok_endp_q   <= '0;
      sof_valid_q  <= 1'b0;
      sof_frame_q  <= '0;
      hs_valid_q   <= 1'b0;
      hs_pid_q     <= '0;
      dat_start_q  <= 1'b0;
      dat_pid_q    <= '0;
      dat_byte_q   <= '0;
      dat_strobe_q <= 1'b0;
      dat_end_q    <= 1'b0;
      dat_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      // Pulses default low; held values keep their last setting
      tok_valid_q  <= 1'b0;
      sof_valid_q  <= 1'b0;
      hs_valid_q   <= 1'b0;
      dat_start_q  <= 1'b0;
      dat_strobe_q <= 1'b0;
      dat_end_q    <= 1'b0;
      dat_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      fresh_q      <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          field_q <= '0;
          crc5_q  <= CRC5_INIT;
          crc16_q <= CRC16_INIT;
          hold0_q <= '0;
          hold1_q <= '0;
          ovf_q   <= 1'b0;
          // A packet already in flight right after reset is ignored entirely
          if (rx_active_q) state_q <= fresh_q ? ST_WAIT_IDLE : ST_PID;
        end

        ST_PID: begin
          if (rx_error_q) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_RX;
            state_q    <= ST_WAIT_IDLE;
          end else if (rx_valid_q) begin
            pid_q <= rx_data_q[3:0];
            if (rx_data_q[7:4] != ~rx_data_q[3:0]) begin
              pkt_err_q  <= 1'b1;
              err_code_q <= ERR_PID;
              state_q    <= ST_WAIT_IDLE;
            end else begin
              unique case (rx_data_q[1:0])
                2'b01: begin
                  if (rx_active_q) state_q <= ST_TOKEN;
                  else begin
                    // Token PID alone, then EOP: no address/CRC bytes
                    pkt_err_q  <= 1'b1;
                    err_code_q <= ERR_LEN;
                    state_q    <= ST_IDLE;
                  end
                end
                2'b11: begin
                  dat_start_q <= 1'b1;
                  dat_pid_q   <= rx_data_q[3:0];
                  if (rx_active_q) state_q <= ST_DATA;
                  else begin
                    // Data PID alone, then EOP: too short to carry CRC16
                    dat_end_q  <= 1'b1;
                    pkt_err_q  <= 1'b1;
                    err_code_q <= ERR_LEN;
                    state_q    <= ST_IDLE;
                  end
                end
                2'b10: begin
                  if (rx_active_q) state_q <= ST_HSHK;
                  else begin
                    hs_valid_q <= 1'b1;
                    hs_pid_q   <= rx_data_q[3:0];
                    state_q    <= ST_IDLE;
                  end
                end
                default: begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= ERR_UNSUP;
                  state_q    <= ST_WAIT_IDLE;
                end
              endcase
            end
          end else if (!rx_active_q) begin
            // Activity with no bytes at all: nothing to report
            state_q <= ST_IDLE;
          end
        end

        ST_TOKEN: begin
          if (rx_error_q) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_RX;
            state_q    <= ST_WAIT_IDLE;
          end else begin
            cnt_q   <= cnt_d;
            field_q <= field_d;
            crc5_q  <= crc5_d;
            if (!rx_active_q) begin
              state_q <= ST_IDLE;
              if (cnt_d != CNT_W'(2)) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_LEN;
              end else if (crc5_d != CRC5_RES) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_CRC;
              end else if (pid_q == PID_SOF) begin
                sof_valid_q <= 1'b1;
                sof_frame_q <= field_d;
              end else if (field_d[6:0] == dev_addr_q) begin
                tok_valid_q <= 1'b1;
                tok_pid_q   <= pid_q;
                tok_endp_q  <= field_d[10:7];
              end
            end
          end
        end

        ST_DATA: begin
          if (rx_error_q) begin
            dat_end_q  <= 1'b1;
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_RX;
            state_q    <= ST_WAIT_IDLE;
          end else begin
            cnt_q   <= cnt_d;
            crc16_q <= crc16_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            ovf_q   <= ovf_d;
            if (strobe_d) begin
              dat_strobe_q <= 1'b1;
              dat_byte_q   <= hold0_q;
            end
            if (!rx_active_q) begin
              dat_end_q <= 1'b1;
              state_q   <= ST_IDLE;
              if (cnt_d < CNT_W'(2)) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_LEN;
              end else if (ovf_d) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_OVF;
              end else if (crc16_d != CRC16_RES) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_CRC;
              end else begin
                dat_ok_q <= 1'b1;
              end
            end
          end
        end

        ST_HSHK: begin
          if (rx_error_q) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_RX;
            state_q    <= ST_WAIT_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (!rx_active_q) begin
              state_q <= ST_IDLE;
              if (cnt_d == CNT_W'(0)) begin
                hs_valid_q <= 1'b1;
                hs_pid_q   <= pid_q;
              end else begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_LEN;
              end
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (!rx_active_q) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tok_valid  = tok_valid_q;
  assign bus.tok_pid    = tok_pid_q;
  assign bus.tok_endp   = tok_endp_q;
  assign bus.sof_valid  = sof_valid_q;
  assign bus.sof_frame  = sof_frame_q;
  assign bus.hs_valid   = hs_valid_q;
  assign bus.hs_pid     = hs_pid_q;
  assign bus.dat_start  = dat_start_q;
  assign bus.dat_pid    = dat_pid_q;
  assign bus.dat_byte   = dat_byte_q;
  assign bus.dat_strobe = dat_strobe_q;
  assign bus.dat_end    = dat_end_q;
  assign bus.dat_ok     = dat_ok_q;
  assign bus.pkt_err    = pkt_err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
Packet-level controller sitting between the USB low/full-speed byte receiver and the SIE/endpoint logic.
- Consumes the receiver's byte stream (data/active/valid/error) and sequences each packet from PID through end of packet.
- Checks PID, length and CRC5/CRC16, and filters tokens by device address.
- Emits one registered event per packet: token, SOF, handshake, or data stream with end status.
- Strips CRC bytes from data payloads via a 2-byte holdback pipeline.

Parameters:
MAX_PAYLOAD, 64, max data-packet payload bytes excluding PID/CRC; 1..1023.
CNT_W, 11, width of internal byte counter; must hold MAX_PAYLOAD+3.

Ports:
clk  in  1  system clock (24 MHz)
reset_n  in  1  synchronous reset, active low
rx_data  in  8  received byte from byte receiver
rx_active  in  1  high between SYNC and EOP
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_error  in  1  receiver error strobe
dev_addr  in  7  assigned device address
tok_valid  out  1  pulse: good token (OUT/IN/SETUP) addressed to dev_addr
tok_pid  out  4  PID[3:0] of token
tok_endp  out  4  endpoint field of token
sof_valid  out  1  pulse: good SOF
sof_frame  out  11  frame number
hs_valid  out  1  pulse: good handshake
hs_pid  out  4  handshake PID[3:0]
dat_start  out  1  pulse: data packet PID accepted
dat_pid  out  4  data PID[3:0], held until next dat_start
dat_byte  out  8  payload byte
dat_strobe  out  1  pulse: dat_byte valid
dat_end  out  1  pulse: data packet finished
dat_ok  out  1  with dat_end: 1 = CRC16 and length good
pkt_err  out  1  pulse: packet rejected
err_code  out  3  error cause, held until next pkt_err

Behaviour:
- Reset (reset_n=0 at posedge clk): state=IDLE; all outputs 0; counters, CRC and holdback registers cleared. After release, if rx_active=1, enter WAIT_IDLE; no events until rx_active is sampled 0.
- Inputs are registered as-is; rx_valid strobes are ≥8 clk apart.
- End of packet (EOP) = first cycle rx_active is sampled 0 after 1. All end-of-packet result pulses are asserted in the cycle after EOP, for exactly 1 cycle.
- States: IDLE, PID, TOKEN, DATA, HSHK, WAIT_IDLE.
- IDLE -> PID on rx_active=1.
- PID, first rx_valid:
  - Require rx_data[7:4] == ~rx_data[3:0]; else pkt_err, err_code=1, go to WAIT_IDLE.
  - PID[1:0]=01 (token) -> TOKEN. PID=0011/1011/0111/1111 (data) -> DATA, with dat_start pulse next cycle and dat_pid latched. PID[1:0]=10 (handshake) -> HSHK.
  - Any other PID -> pkt_err, err_code=6, go to WAIT_IDLE.
- TOKEN:
  - Collect exactly 2 bytes into a 16-bit field, byte1 in bits 7:0.
  - CRC5: shift-right LFSR, poly 0x14, init 0x1F, LSB-first over all 16 bits; pass when remainder = 0x06.
  - At EOP:
    - byte count ≠ 2 -> pkt_err, code 3.
    - else CRC fail -> code 2.
    - else SOF (0101) -> sof_valid, sof_frame = field[10:0].
    - else field[6:0] = dev_addr -> tok_valid, tok_endp = field[10:7].
    - else silently dropped (no pulse).
- HSHK: at EOP, 0 extra bytes -> hs_valid; otherwise pkt_err, code 3.
- DATA:
  - CRC16: shift-right LFSR, poly 0xA001, init 0xFFFF, LSB-first over every byte after the PID; pass when remainder = 0xB001.
  - Each received byte enters a 2-deep holdback. When a third byte arrives, the oldest is output: dat_byte with dat_strobe in the cycle after that rx_valid. The final 2 bytes (CRC) are never output.
  - Payload count > MAX_PAYLOAD: stop strobing, set overflow flag.
  - At EOP: dat_end=1 in every case. dat_ok=1 only if CRC passes, byte count ≥ 2, and no overflow.
  - When dat_ok=0, pkt_err is asserted in the same cycle: code 3 for count < 2, code 5 for overflow, code 2 for CRC (priority 3 > 5 > 2).
- rx_error=1 in any non-IDLE state:
  - pkt_err, code 4, next cycle. If in DATA, dat_end=1 and dat_ok=0 in the same cycle.
  - Go to WAIT_IDLE; no further events for that packet.
- WAIT_IDLE -> IDLE when rx_active is sampled 0. No end-of-packet pulses are produced from WAIT_IDLE.
- rx_active dropping with 0 bytes: no event, return to IDLE.
- Simultaneous rx_valid and EOP: the byte is processed before the end-of-packet decision.
- err_code values: 1 PID check, 2 CRC, 3 length, 4 rx_error, 5 overflow, 6 unsupported PID.

Test Plan:
- SETUP to addr 0, endp 0: bytes 2D 00 10, dev_addr=0 -> tok_valid, tok_pid=D, tok_endp=0. Repeat with dev_addr=5 -> no pulse, no pkt_err.
- DATA0: C3 80 06 00 01 00 00 40 00 DD 94 -> dat_start with dat_pid=3; 8 dat_strobes 80,06,00,01,00,00,40,00; dat_end with dat_ok=1. Flip one payload bit -> dat_ok=0, pkt_err code 2.
- Zero-length DATA1: 4B 00 00 -> dat_start, no dat_strobe, dat_end with dat_ok=1. Packet 4B 00 -> pkt_err code 3.
- ACK D2 -> hs_valid, hs_pid=2. Bad PID 2C -> pkt_err code 1. PRE 3C -> pkt_err code 6.
- DATA0 with MAX_PAYLOAD+1 = 65 payload bytes plus valid CRC -> exactly 64 dat_strobes, dat_ok=0, pkt_err code 5.
- reset_n low mid-data packet while rx_active=1 -> all outputs 0 next cycle, no events until rx_active falls. A following ACK decodes normally. rx_error mid-token -> pkt_err code 4, no tok_valid.
